// File: rtl/vx_csr_sequencer_if.sv
// Requester, response and CSR-file signals of the CSR sequencer.
// The slave modport is the sequencer's view; master is the environment's.
interface vx_csr_sequencer_if #(
    parameter int NUM_REQS  = 4,
    parameter int ADDR_BITS = 12,
    parameter int WID_BITS  = 2
);
    localparam int IDXW = $clog2(NUM_REQS);

    logic [NUM_REQS-1:0]           req_valid;
    logic [NUM_REQS-1:0]           req_ready;
    logic [NUM_REQS*2-1:0]         req_op;
    logic [NUM_REQS*ADDR_BITS-1:0] req_addr;
    logic [NUM_REQS*WID_BITS-1:0]  req_wid;
    logic [NUM_REQS*32-1:0]        req_data;

    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [IDXW-1:0]               rsp_idx;
    logic [31:0]                   rsp_data;

    logic                          csr_read_enable;
    logic [ADDR_BITS-1:0]          csr_read_addr;
    logic [WID_BITS-1:0]           csr_read_wid;
    logic [31:0]                   csr_read_data;

    logic                          csr_write_enable;
    logic [ADDR_BITS-1:0]          csr_write_addr;
    logic [WID_BITS-1:0]           csr_write_wid;
    logic [31:0]                   csr_write_data;

    logic                          busy;

    modport slave (
        input  req_valid, req_op, req_addr, req_wid, req_data,
        output req_ready,
        output rsp_valid, rsp_idx, rsp_data,
        input  rsp_ready,
        output csr_read_enable, csr_read_addr, csr_read_wid,
        input  csr_read_data,
        output csr_write_enable, csr_write_addr, csr_write_wid,
        output csr_write_data,
        output busy
    );

    modport master (
        output req_valid, req_op, req_addr, req_wid, req_data,
        input  req_ready,
        input  rsp_valid, rsp_idx, rsp_data,
        output rsp_ready,
        input  csr_read_enable, csr_read_addr, csr_read_wid,
        output csr_read_data,
        input  csr_write_enable, csr_write_addr, csr_write_wid,
        input  csr_write_data,
        input  busy
    );
endinterface

// File: rtl/vx_csr_sequencer.sv
// Round-robin CSR read-modify-write sequencer, one transaction in flight:
// IDLE grants, READ samples the CSR, WRITE updates it, RESP returns old value.
module vx_csr_sequencer #(
    parameter int NUM_REQS  = 4,
    parameter int ADDR_BITS = 12,
    parameter int WID_BITS  = 2
) (
    input  logic              clk,
    input  logic              reset,
    vx_csr_sequencer_if.slave bus
);
    localparam int IDXW = $clog2(NUM_REQS);

    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RESP
    } state_e;

    function automatic logic [IDXW-1:0] wrap_idx(
        input logic [IDXW-1:0] base,
        input int              off
    );
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQS) s = s - NUM_REQS;
        return IDXW'(s);
    endfunction

    logic [1:0]           op_arr   [NUM_REQS];
    logic [ADDR_BITS-1:0] addr_arr [NUM_REQS];
    logic [WID_BITS-1:0]  wid_arr  [NUM_REQS];
    logic [31:0]          data_arr [NUM_REQS];

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_unpack
        assign op_arr[g]   = bus.req_op[g*2 +: 2];
        assign addr_arr[g] = bus.req_addr[g*ADDR_BITS +: ADDR_BITS];
        assign wid_arr[g]  = bus.req_wid[g*WID_BITS +: WID_BITS];
        assign data_arr[g] = bus.req_data[g*32 +: 32];
    end

    state_e               state_q, state_d;
    logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic [1:0]           op_q, op_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [WID_BITS-1:0]  wid_q, wid_d;
    logic [31:0]          data_q, data_d;
    logic [31:0]          old_q, old_d;

    logic                 rd_en_q, rd_en_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic [WID_BITS-1:0]  rd_wid_q, rd_wid_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [WID_BITS-1:0]  wr_wid_q, wr_wid_d;
    logic [31:0]          wr_data_q, wr_data_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [IDXW-1:0]      rsp_idx_q, rsp_idx_d;
    logic [31:0]          rsp_data_q, rsp_data_d;

    logic                 gnt_found;
    logic [IDXW-1:0]      gnt_idx;
    logic [IDXW-1:0]      cand;
    logic [NUM_REQS-1:0]  ready;
    logic                 need_wr;
    logic [31:0]          wr_val;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            cand = wrap_idx(rr_ptr_q, i);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Write decision and value, using the CSR value read this cycle.
    always_comb begin
        need_wr = 1'b0;
        wr_val  = data_q;
        unique case (1'b1)
            (op_q == OP_RD): need_wr = 1'b0;
            (op_q == OP_RW): need_wr = 1'b1;
            (op_q == OP_RS): begin
                need_wr = |data_q;
                wr_val  = bus.csr_read_data | data_q;
            end
            (op_q == OP_RC): begin
                need_wr = |data_q;
                wr_val  = bus.csr_read_data & ~data_q;
            end
            default: need_wr = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        idx_d       = idx_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wid_d       = wid_q;
        data_d      = data_q;
        old_d       = old_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = '0;
        rd_wid_d    = '0;
        wr_en_d     = 1'b0;
        wr_addr_d   = '0;
        wr_wid_d    = '0;
        wr_data_d   = '0;
        rsp_valid_d = 1'b0;
        rsp_idx_d   = '0;
        rsp_data_d  = '0;
        ready       = '0;

        unique case (state_q)
            S_IDLE: begin
                // reset gates the combinational ready path as well
                if (gnt_found && reset) begin
                    ready[gnt_idx] = 1'b1;
                    idx_d          = gnt_idx;
                    op_d           = op_arr[gnt_idx];
                    addr_d         = addr_arr[gnt_idx];
                    wid_d          = wid_arr[gnt_idx];
                    data_d         = data_arr[gnt_idx];
                    rr_ptr_d       = wrap_idx(gnt_idx, 1);
                    state_d        = S_READ;
                    rd_en_d        = 1'b1;
                    rd_addr_d      = addr_arr[gnt_idx];
                    rd_wid_d       = wid_arr[gnt_idx];
                end
            end
            S_READ: begin
                old_d = bus.csr_read_data;
                if (need_wr) begin
                    state_d   = S_WRITE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_wid_d  = wid_q;
                    wr_data_d = wr_val;
                end else begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_idx_d   = idx_q;
                    rsp_data_d  = bus.csr_read_data;
                end
            end
            S_WRITE: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_idx_d   = idx_q;
                rsp_data_d  = old_q;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_idx_d   = idx_q;
                    rsp_data_d  = old_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            idx_q       <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            wid_q       <= '0;
            data_q      <= '0;
            old_q       <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_wid_q    <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_wid_q    <= '0;
            wr_data_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wid_q       <= wid_d;
            data_q      <= data_d;
            old_q       <= old_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            rd_wid_q    <= rd_wid_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_wid_q    <= wr_wid_d;
            wr_data_q   <= wr_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.req_ready        = ready;
    assign bus.rsp_valid        = rsp_valid_q;
    assign bus.rsp_idx          = rsp_idx_q;
    assign bus.rsp_data         = rsp_data_q;
    assign bus.csr_read_enable  = rd_en_q;
    assign bus.csr_read_addr    = rd_addr_q;
    assign bus.csr_read_wid     = rd_wid_q;
    assign bus.csr_write_enable = wr_en_q;
    assign bus.csr_write_addr   = wr_addr_q;
    assign bus.csr_write_wid    = wr_wid_q;
    assign bus.csr_write_data   = wr_data_q;
    assign bus.busy             = (state_q != S_IDLE);
endmodule
